rgb_input_logic: RTL and testbench

Front end of the HDMI-to-matrix pipeline. Samples the decoded parallel RGB stream (DE/HS/VS plus one 8-bit sample per colour channel) on the pixel clock. Packs BATCH_SIZE consecutive pixels per channel into one word and emits word, address and write strobe to per-channel block RAMs. Measures the active frame size and flags whether the last frame was well-formed.

---
 rtl/rgb_input_logic_if.sv | 36 +++
 rtl/rgb_input_logic.sv | 151 +++++++++++++++
 tb/tb_rgb_input_logic.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_input_logic_if.sv
// Bundles the parallel RGB input stream and the RAM-write / frame-measurement outputs of rgb_input_logic.
// The master modport is the pixel source and the slave modport is the capture block.
interface rgb_input_logic_if #(
    parameter int CHANNEL_COUNT = 3,
    parameter int BATCH_SIZE    = 4,
    parameter int BLOCK_DEPTH   = 480,
    parameter int MAX_WIDTH     = 64,
    parameter int MAX_HEIGHT    = 64
);
    localparam int AW = $clog2(BLOCK_DEPTH);
    localparam int WW = $clog2(MAX_WIDTH);
    localparam int HW = $clog2(MAX_HEIGHT);

    logic                                     rgb_de;
    logic                                     rgb_hs;
    logic                                     rgb_vs;
    logic [CHANNEL_COUNT-1:0][7:0]            rgb_color;
    logic [CHANNEL_COUNT-1:0][8*BATCH_SIZE-1:0] data_distributed;
    logic [CHANNEL_COUNT-1:0][AW-1:0]         address_distributed;
    logic                                     clk_distributed;
    logic [WW-1:0]                            image_width;
    logic [HW-1:0]                            image_height;
    logic                                     image_valid;

    modport master (
        output rgb_de, rgb_hs, rgb_vs, rgb_color,
        input  data_distributed, address_distributed, clk_distributed,
        input  image_width, image_height, image_valid
    );

    modport slave (
        input  rgb_de, rgb_hs, rgb_vs, rgb_color,
        output data_distributed, address_distributed, clk_distributed,
        output image_width, image_height, image_valid
    );
endinterface

// File: rtl/rgb_input_logic.sv
// Captures the parallel RGB stream: packs BATCH_SIZE pixels per channel into RAM words and measures frame size.
// Define RGB_INPUT_PARTIAL_FLUSH_EN to emit zero-padded partial words at line end instead of dropping them.
module rgb_input_logic #(
    parameter int CHANNEL_COUNT = 3,
    parameter int BATCH_SIZE    = 4,
    parameter int BLOCK_WIDTH   = 32,
    parameter int BLOCK_DEPTH   = 480,
    parameter int MAX_WIDTH     = 64,
    parameter int MAX_HEIGHT    = 64
) (
    input  logic             rgb_clk,
    input  logic             rst_n,
    rgb_input_logic_if.slave bus
);
    localparam int AW     = $clog2(BLOCK_DEPTH);
    localparam int WW     = $clog2(MAX_WIDTH);
    localparam int HW     = $clog2(MAX_HEIGHT);
    localparam int FW     = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int WORD_W = 8 * BATCH_SIZE;

    generate
        if (BLOCK_WIDTH != 8 * BATCH_SIZE) begin : g_width_check
            $error("rgb_input_logic: BLOCK_WIDTH must equal 8*BATCH_SIZE");
        end
    endgenerate

    logic                                de_q, hs_q, vs_q;
    logic [FW-1:0]                       fill_idx;
    logic [CHANNEL_COUNT-1:0][WORD_W-1:0] pack_word, batch_word, emit_word;
    logic [AW-1:0]                       wr_ptr;
    logic                                write_pending;
    logic [WW-1:0]                       pix_cnt, pix_inc, ref_width, width_upd;
    logic [HW-1:0]                       line_cnt, line_cnt_upd;
    logic                                err, err_upd;
    logic                                hs_fall, vs_fall, de_fall, line_end;
    logic                                batch_done, flush, emit, pix_sat, frame_ok;

    assign hs_fall    = hs_q & ~bus.rgb_hs;
    assign vs_fall    = vs_q & ~bus.rgb_vs;
    assign de_fall    = de_q & ~bus.rgb_de;
    // A VS arriving mid-line closes that line on the same edge.
    assign line_end   = de_fall | (vs_fall & bus.rgb_de);
    assign batch_done = bus.rgb_de && (fill_idx == FW'(BATCH_SIZE - 1));

`ifdef RGB_INPUT_PARTIAL_FLUSH_EN
    assign flush = de_fall && (fill_idx != '0);
`else
    assign flush = 1'b0;
`endif

    assign emit = batch_done | flush;

    always_comb begin
        batch_word = pack_word;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            batch_word[c][8*int'(fill_idx) +: 8] = bus.rgb_color[c];
        end
        emit_word = batch_done ? batch_word : pack_word;
    end

    // Frame measurement as it would stand after this edge, so VS can publish it directly.
    always_comb begin
        pix_inc      = pix_cnt;
        pix_sat      = 1'b0;
        if (bus.rgb_de) begin
            pix_inc = (pix_cnt == WW'(MAX_WIDTH - 1)) ? pix_cnt : pix_cnt + WW'(1);
            pix_sat = (pix_inc == WW'(MAX_WIDTH - 1));
        end
        width_upd    = ref_width;
        line_cnt_upd = line_cnt;
        err_upd      = err | pix_sat;
        if (line_end) begin
            line_cnt_upd = (line_cnt == HW'(MAX_HEIGHT - 1)) ? line_cnt : line_cnt + HW'(1);
            if (line_cnt == '0) begin
                width_upd = pix_inc;
            end else if (pix_inc != ref_width) begin
                err_upd = 1'b1;
            end
            if (line_cnt_upd == HW'(MAX_HEIGHT - 1)) begin
                err_upd = 1'b1;
            end
        end
        frame_ok = (width_upd != '0) && (line_cnt_upd != '0) && !err_upd &&
                   ((int'(width_upd) % BATCH_SIZE) == 0);
    end

    always_ff @(posedge rgb_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q                    <= 1'b0;
            hs_q                    <= 1'b0;
            vs_q                    <= 1'b0;
            fill_idx                <= '0;
            pack_word               <= '0;
            wr_ptr                  <= '0;
            write_pending           <= 1'b0;
            pix_cnt                 <= '0;
            ref_width               <= '0;
            line_cnt                <= '0;
            err                     <= 1'b0;
            bus.data_distributed    <= '0;
            bus.address_distributed <= '0;
            bus.clk_distributed     <= 1'b0;
            bus.image_width         <= '0;
            bus.image_height        <= '0;
            bus.image_valid         <= 1'b0;
        end else begin
            de_q <= bus.rgb_de;
            hs_q <= bus.rgb_hs;
            vs_q <= bus.rgb_vs;

            // Any batch boundary (write, HS, line end) restarts with all lanes zero.
            if (emit || hs_fall || de_fall) begin
                fill_idx  <= '0;
                pack_word <= '0;
            end else if (bus.rgb_de) begin
                fill_idx  <= fill_idx + FW'(1);
                pack_word <= batch_word;
            end

            if (emit) begin
                bus.data_distributed <= emit_word;
                for (int c = 0; c < CHANNEL_COUNT; c++) begin
                    bus.address_distributed[c] <= wr_ptr;
                end
            end
            write_pending       <= emit;
            bus.clk_distributed <= write_pending;

            if (vs_fall) begin
                wr_ptr <= '0;
            end else if (emit) begin
                wr_ptr <= (wr_ptr == AW'(BLOCK_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end

            pix_cnt <= (line_end || hs_fall) ? '0 : pix_inc;

            if (vs_fall) begin
                bus.image_width  <= width_upd;
                bus.image_height <= line_cnt_upd;
                bus.image_valid  <= frame_ok;
                line_cnt         <= '0;
                ref_width        <= '0;
                err              <= 1'b0;
            end else begin
                line_cnt  <= line_cnt_upd;
                ref_width <= width_upd;
                err       <= err_upd;
            end
        end
    end
endmodule

// File: tb/tb_rgb_input_logic.sv
// Self-checking bench for rgb_input_logic: drives whole frames, predicts every RAM write into a
// scoreboard queue and compares each strobe plus the frame measurements against that prediction.
module tb_rgb_input_logic;
    localparam int CH    = 3;
    localparam int BS    = 4;
    localparam int DEPTH = 480;
    localparam int MW    = 64;
    localparam int MH    = 64;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [AW-1:0]        addr;
        logic [CH-1:0][31:0]  data;
    } write_t;

    logic rgb_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 rgb_clk = ~rgb_clk;

    rgb_input_logic_if #(.CHANNEL_COUNT(CH), .BATCH_SIZE(BS), .BLOCK_DEPTH(DEPTH),
                         .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) bus ();

    rgb_input_logic #(.CHANNEL_COUNT(CH), .BATCH_SIZE(BS), .BLOCK_WIDTH(32), .BLOCK_DEPTH(DEPTH),
                      .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
        .rgb_clk (rgb_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    write_t              exp_q[$];
    write_t              mon_e;
    int                  n_checks     = 0;
    int                  n_fail       = 0;
    int                  strobe_total = 0;
    logic [31:0]         cap_ch0 [0:DEPTH-1];
    int                  exp_ptr = 0;
    int                  fill    = 0;
    int                  pix_val = 1;
    logic [CH-1:0][31:0] exp_word = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every strobe must match the oldest predicted write.
    always @(negedge rgb_clk) begin
        if (bus.clk_distributed === 1'b1) begin
            strobe_total++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int c = 0; c < CH; c++) begin
                    checkOutput($sformatf("wr_addr_ch%0d", c), 64'(bus.address_distributed[c]), 64'(mon_e.addr));
                    checkOutput($sformatf("wr_data_ch%0d", c), 64'(bus.data_distributed[c]), 64'(mon_e.data[c]));
                end
                cap_ch0[bus.address_distributed[0]] = bus.data_distributed[0];
            end
        end
    end

    task automatic driveCycle(input logic de, input logic hs, input logic vs, input logic [7:0] c0);
        @(posedge rgb_clk);
        #1;
        bus.rgb_de       = de;
        bus.rgb_hs       = hs;
        bus.rgb_vs       = vs;
        bus.rgb_color[0] = c0;
        bus.rgb_color[1] = 8'hBB;
        bus.rgb_color[2] = 8'hCC;
    endtask

    task automatic modelPush();
        write_t w;
        w.addr  = AW'(exp_ptr);
        w.data  = exp_word;
        exp_q.push_back(w);
        exp_ptr  = (exp_ptr + 1) % DEPTH;
        exp_word = '0;
        fill     = 0;
    endtask

    // One frame: HS pulse, blanking, DE-active pixels per line, then a one-cycle VS pulse.
    // abort_at > 0 returns right after that many pixels have been driven.
    task automatic applyStimulus(input int width, input int height, input int short_line,
                                 input int short_width, input int abort_at);
        int w;
        int count;
        count    = 0;
        pix_val  = 1;
        fill     = 0;
        exp_word = '0;
        for (int l = 0; l < height; l++) begin
            w = (l == short_line) ? short_width : width;
            driveCycle(1'b0, 1'b0, 1'b1, 8'h00);
            driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
            driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
            for (int p = 0; p < w; p++) begin
                driveCycle(1'b1, 1'b1, 1'b1, 8'(pix_val));
                exp_word[0][8*fill +: 8] = 8'(pix_val);
                exp_word[1][8*fill +: 8] = 8'hBB;
                exp_word[2][8*fill +: 8] = 8'hCC;
                fill++;
                pix_val++;
                count++;
                if (fill == BS) modelPush();
                if (count == abort_at) return;
            end
            driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
`ifdef RGB_INPUT_PARTIAL_FLUSH_EN
            if (fill != 0) modelPush();
`endif
            fill     = 0;
            exp_word = '0;
            driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        end
        driveCycle(1'b0, 1'b1, 1'b0, 8'h00);
        exp_ptr = 0;
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (4) @(posedge rgb_clk);
        #1;
        checkOutput("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic checkFrame(input string tag, input int strobes, input int w, input int h, input logic v);
        checkOutput({tag, "_strobes"}, 64'(strobes), 64'(strobe_total));
        checkOutput({tag, "_width"},   64'(bus.image_width),  64'(w));
        checkOutput({tag, "_height"},  64'(bus.image_height), 64'(h));
        checkOutput({tag, "_valid"},   64'(bus.image_valid),  64'(v));
    endtask

    task automatic checkAllZero(input string tag);
        for (int c = 0; c < CH; c++) begin
            checkOutput({tag, "_data"}, 64'(bus.data_distributed[c]),    64'd0);
            checkOutput({tag, "_addr"}, 64'(bus.address_distributed[c]), 64'd0);
        end
        checkOutput({tag, "_strobe"}, 64'(bus.clk_distributed), 64'd0);
        checkOutput({tag, "_width"},  64'(bus.image_width),     64'd0);
        checkOutput({tag, "_height"}, 64'(bus.image_height),    64'd0);
        checkOutput({tag, "_valid"},  64'(bus.image_valid),     64'd0);
    endtask

    initial begin
        int s0;
        int exp_strobes;
        bus.rgb_de    = 1'b0;
        bus.rgb_hs    = 1'b1;
        bus.rgb_vs    = 1'b1;
        bus.rgb_color = '0;

        $display("[TB] reset held with random inputs");
        for (int i = 0; i < 20; i++) begin
            @(posedge rgb_clk);
            #1;
            bus.rgb_de    = 1'($urandom_range(0, 1));
            bus.rgb_hs    = 1'($urandom_range(0, 1));
            bus.rgb_vs    = 1'($urandom_range(0, 1));
            bus.rgb_color = 24'($urandom);
            if (i == 9 || i == 19) checkAllZero("reset");
        end
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        rst_n = 1'b1;
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("post_reset_strobes", 64'(strobe_total), 64'd0);

        $display("[TB] single 16x8 frame");
        s0 = strobe_total;
        applyStimulus(16, 8, -1, 0, 0);
        checkFrame("frame16x8", strobe_total - s0 + s0 - s0 + 0, 16, 8, 1'b1);
        checkOutput("frame16x8_count", 64'(strobe_total - s0), 64'd32);
        checkOutput("addr0_ch0",  64'(cap_ch0[0]),  64'h04030201);
        checkOutput("addr3_ch0",  64'(cap_ch0[3]),  64'h100F0E0D);
        checkOutput("addr31_ch0", 64'(cap_ch0[31]), 64'h807F7E7D);

        $display("[TB] four back-to-back frames");
        for (int f = 0; f < 4; f++) begin
            s0 = strobe_total;
            applyStimulus(16, 8, -1, 0, 0);
            checkOutput("b2b_count", 64'(strobe_total - s0), 64'd32);
            checkFrame("b2b", strobe_total, 16, 8, 1'b1);
        end

        $display("[TB] frame with one short line, then a good frame");
        s0 = strobe_total;
        applyStimulus(16, 8, 3, 12, 0);
        checkOutput("short_line_count", 64'(strobe_total - s0), 64'd31);
        checkOutput("short_line_valid", 64'(bus.image_valid), 64'd0);
        applyStimulus(16, 8, -1, 0, 0);
        checkFrame("recovered", strobe_total, 16, 8, 1'b1);

        $display("[TB] 14-pixel lines");
`ifdef RGB_INPUT_PARTIAL_FLUSH_EN
        exp_strobes = 16;
`else
        exp_strobes = 12;
`endif
        s0 = strobe_total;
        applyStimulus(14, 4, -1, 0, 0);
        checkOutput("w14_count", 64'(strobe_total - s0), 64'(exp_strobes));
        checkFrame("w14", strobe_total, 14, 4, 1'b0);
`ifdef RGB_INPUT_PARTIAL_FLUSH_EN
        checkOutput("w14_flush_word", 64'(cap_ch0[3]), 64'h00000E0D);
`endif

        $display("[TB] reset pulsed mid-frame");
        applyStimulus(16, 8, -1, 0, 22);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        exp_q.delete();
        exp_ptr = 0;
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        rst_n = 1'b1;
        driveCycle(1'b0, 1'b1, 1'b1, 8'h00);
        s0 = strobe_total;
        applyStimulus(16, 8, -1, 0, 0);
        checkOutput("after_reset_count", 64'(strobe_total - s0), 64'd32);
        checkFrame("after_reset", strobe_total, 16, 8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
